// File: rtl/gpio_loader_pkg.sv
// gpio_loader_pkg: shared types and sizing helpers for the GPIO serial loader.
// Build option: GPIO_LOADER_AUTOSTART_EN (see gpio_serial_loader).
package gpio_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  localparam int unsigned DEF_CFG_BITS = 13;

  // Bits carried by one of the two chains.
  function automatic int unsigned chain_bits(
    input int unsigned num_io,
    input int unsigned cfg_bits
  );
    return (num_io / 2) * cfg_bits;
  endfunction

endpackage

// File: rtl/gpio_loader_clkgen.sv
// gpio_loader_clkgen: divides clock into the chain shift clock.
// Emits one-cycle strobes on the cycle before each rise/fall.
module gpio_loader_clkgen #(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic clock,
  input  logic resetn,
  input  logic run,
  output logic sclk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int unsigned DW = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] cnt_q;
  logic          phase_q;
  logic          wrap;

  assign wrap = run && (cnt_q == LAST);

  // Half-period counter and phase; parked low while not running.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (!run) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (wrap) begin
      cnt_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q   <= cnt_q + DW'(1);
    end
  end

  assign sclk      = phase_q;
  assign rise_tick = wrap && !phase_q;
  assign fall_tick = wrap &&  phase_q;

endmodule

// File: rtl/gpio_serial_loader.sv
// gpio_serial_loader: shifts pad config words into two GPIO control chains.
// Build option: GPIO_LOADER_AUTOSTART_EN starts one load right after reset.
module gpio_serial_loader
  import gpio_loader_pkg::*;
#(
  parameter int unsigned NUM_IO   = 38,
  parameter int unsigned CFG_BITS = DEF_CFG_BITS,
  parameter int unsigned CLK_DIV  = 1
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       start,
  input  logic [NUM_IO*CFG_BITS-1:0] cfg_data,
  output logic                       busy,
  output logic                       done,
  output logic                       serial_clock,
  output logic                       serial_load,
  output logic                       serial_resetn,
  output logic                       serial_data_1,
  output logic                       serial_data_2
);

  localparam int unsigned HALF  = NUM_IO / 2;
  localparam int unsigned NBITS = chain_bits(NUM_IO, CFG_BITS);
  localparam int unsigned BW    = $clog2(NBITS + 1);
  localparam logic [BW-1:0] BIT_END = BW'(NBITS);

  if ((NUM_IO % 2) != 0 || NUM_IO == 0) begin : g_bad_io
    $error("gpio_serial_loader: NUM_IO must be even and nonzero");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("gpio_serial_loader: CLK_DIV must be >= 1");
  end

  state_t           state_q;
  state_t           state_d;
  logic [NBITS-1:0] img1;
  logic [NBITS-1:0] img2;
  logic [NBITS-1:0] sr1_q;
  logic [NBITS-1:0] sr2_q;
  logic [BW-1:0]    bit_q;
  logic             done_q;
  logic             srst_q;
  logic             start_int;
  logic             go;
  logic             seq_end;
  logic             sclk;
  logic             rise_tick;
  logic             fall_tick;

  // Chain 1 leaves pad HALF-1 first: the low half is already in order.
  assign img1 = cfg_data[NBITS-1:0];

  // Chain 2 leaves pad HALF first: reverse the pad order of the high half.
  for (genvar k = 0; k < HALF; k++) begin : g_c2
    assign img2[(HALF-1-k)*CFG_BITS +: CFG_BITS] =
      cfg_data[(HALF+k)*CFG_BITS +: CFG_BITS];
  end

  // Chain reset releases one edge after the system reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) srst_q <= 1'b0;
    else         srst_q <= 1'b1;
  end

`ifdef GPIO_LOADER_AUTOSTART_EN
  logic auto_q;

  // Marks that the one-shot boot load has been requested.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) auto_q <= 1'b0;
    else         auto_q <= srst_q;
  end

  assign start_int = start | (srst_q & ~auto_q);
`else
  assign start_int = start;
`endif

  // The done cycle still belongs to the previous sequence.
  assign go      = (state_q == IDLE) && !done_q && start_int;
  assign seq_end = (state_q == LOAD) && fall_tick;

  gpio_loader_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clock     (clock),
    .resetn    (resetn),
    .run       (state_q != IDLE),
    .sclk      (sclk),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state: shift until every bit was clocked, then one load period.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (go) state_d = SHIFT;
      SHIFT:   if (fall_tick && bit_q == BIT_END) state_d = LOAD;
      LOAD:    if (fall_tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Snapshot on start, count captured bits, advance data on each fall.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sr1_q  <= '0;
      sr2_q  <= '0;
      bit_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= seq_end;
      if (go) begin
        sr1_q <= img1;
        sr2_q <= img2;
        bit_q <= '0;
      end else if (state_q == SHIFT) begin
        if (rise_tick) bit_q <= bit_q + BW'(1);
        if (fall_tick) begin
          sr1_q <= sr1_q << 1;
          sr2_q <= sr2_q << 1;
        end
      end
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign serial_clock  = (state_q == SHIFT) && sclk;
  assign serial_load   = (state_q == LOAD);
  assign serial_resetn = srst_q;
  assign serial_data_1 = (state_q == SHIFT) && sr1_q[NBITS-1];
  assign serial_data_2 = (state_q == SHIFT) && sr2_q[NBITS-1];

endmodule

// File: tb/tb_gpio_serial_loader.sv
// tb_gpio_serial_loader: directed bench for gpio_serial_loader.
// Two instances: CLK_DIV=1 (u_dut1) and CLK_DIV=3 (u_dut3).
module tb_gpio_serial_loader;

  localparam int NIO = 38;
  localparam int CB  = 13;
  localparam int NB  = (NIO / 2) * CB;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic start1 = 1'b0;
  logic start3 = 1'b0;
  logic [NIO*CB-1:0] cfg1;
  logic [NIO*CB-1:0] cfg3;

  logic busy_a, done_a, sclk_a, load_a, srst_a, d1_a, d2_a;
  logic busy_b, done_b, sclk_b, load_b, srst_b, d1_b, d2_b;

  int n_vec = 0;
  int n_bad = 0;

  int m_busy[2], m_rise[2], m_done[2], m_load[2], m_viol[2];
  int m_hmin[2], m_hmax[2], m_lmin[2], m_lmax[2];
  int hrun[2], lrun[2];
  logic pk[2], px[2], py[2];
  bit rx[2][2][NB];
  logic [12:0] ex[2][NIO];

  always #5 clk = ~clk;

  gpio_serial_loader #(.NUM_IO(NIO), .CFG_BITS(CB), .CLK_DIV(1)) u_dut1 (
    .clock(clk), .resetn(resetn), .start(start1), .cfg_data(cfg1),
    .busy(busy_a), .done(done_a), .serial_clock(sclk_a),
    .serial_load(load_a), .serial_resetn(srst_a),
    .serial_data_1(d1_a), .serial_data_2(d2_a)
  );

  gpio_serial_loader #(.NUM_IO(NIO), .CFG_BITS(CB), .CLK_DIV(3)) u_dut3 (
    .clock(clk), .resetn(resetn), .start(start3), .cfg_data(cfg3),
    .busy(busy_b), .done(done_b), .serial_clock(sclk_b),
    .serial_load(load_b), .serial_resetn(srst_b),
    .serial_data_1(d1_b), .serial_data_2(d2_b)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] pat(input int kind, input int n);
    case (kind)
      0:       return 13'h1000 | 13'(n);
      1:       return 13'(n * 311 + 7);
      2:       return 13'(n * 53) ^ 13'h1aaa;
      3:       return 13'h0f0f ^ 13'(n * 7);
      4:       return 13'(n * 1021 + 99);
      default: return 13'h1fff - 13'(n * 41);
    endcase
  endfunction

  task automatic set_cfg(input int u, input int kind, input bit keep);
    for (int n = 0; n < NIO; n++) begin
      if (u == 0) cfg1[n*CB +: CB] = pat(kind, n);
      else        cfg3[n*CB +: CB] = pat(kind, n);
      if (!keep) ex[u][n] = pat(kind, n);
    end
  endtask

  task automatic clr(input int u);
    m_busy[u] = 0; m_rise[u] = 0; m_done[u] = 0;
    m_load[u] = 0; m_viol[u] = 0;
    m_hmin[u] = 9999; m_hmax[u] = 0;
    m_lmin[u] = 9999; m_lmax[u] = 0;
    hrun[u] = 0; lrun[u] = 0;
  endtask

  // Chain model: capture on serial_clock rise, track phase lengths.
  task automatic mon(input int u, input logic b, input logic dn,
                     input logic k, input logic ld,
                     input logic x, input logic y);
    if (b) m_busy[u]++;
    if (dn) m_done[u]++;
    if (ld) m_load[u]++;
    if (k && (x !== px[u] || y !== py[u])) m_viol[u]++;
    if (k && !pk[u]) begin
      if (m_rise[u] < NB) begin
        rx[u][0][m_rise[u]] = x;
        rx[u][1][m_rise[u]] = y;
      end
      m_rise[u]++;
      if (lrun[u] < m_lmin[u]) m_lmin[u] = lrun[u];
      if (lrun[u] > m_lmax[u]) m_lmax[u] = lrun[u];
      lrun[u] = 0;
    end
    if (k) hrun[u]++;
    else if (pk[u]) begin
      if (hrun[u] < m_hmin[u]) m_hmin[u] = hrun[u];
      if (hrun[u] > m_hmax[u]) m_hmax[u] = hrun[u];
      hrun[u] = 0;
    end
    if (b && !k && !ld) lrun[u]++;
    pk[u] = k; px[u] = x; py[u] = y;
  endtask

  always @(negedge clk) mon(0, busy_a, done_a, sclk_a, load_a, d1_a, d2_a);
  always @(negedge clk) mon(1, busy_b, done_b, sclk_b, load_b, d1_b, d2_b);

  function automatic logic [12:0] pad_rx(input int u, input int p);
    logic [12:0] w;
    int c, k;
    c = (p < NIO / 2) ? 0 : 1;
    k = (p < NIO / 2) ? (NIO / 2 - 1 - p) : (p - NIO / 2);
    for (int j = 0; j < CB; j++) w[CB-1-j] = rx[u][c][k*CB + j];
    return w;
  endfunction

  task automatic pulse(input int u);
    @(negedge clk); #1;
    clr(u);
    if (u == 0) start1 = 1'b1; else start3 = 1'b1;
    @(negedge clk); #1;
    if (u == 0) start1 = 1'b0; else start3 = 1'b0;
  endtask

  task automatic wait_done(input int u, input int lim);
    bit seen = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if ((u == 0) ? done_a : done_b) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic wait_rise(input int u, input int n);
    for (int i = 0; i < 4000 && m_rise[u] < n; i++) @(negedge clk);
    chk("rise_reached", 32'(m_rise[u] >= n), 32'd1);
  endtask

  task automatic check_run(input int u, input int bcyc, input int lcyc);
    int bad = 0;
    chk("busy_cycles", m_busy[u], bcyc);
    chk("sclk_rises", m_rise[u], NB);
    chk("done_pulses", m_done[u], 1);
    chk("load_cycles", m_load[u], lcyc);
    chk("data_stable", m_viol[u], 0);
    for (int p = 0; p < NIO; p++)
      if (pad_rx(u, p) !== ex[u][p]) bad++;
    chk("pad_words", bad, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    cfg1 = '0;
    cfg3 = '0;
    pk = '{1'b0, 1'b0}; px = '{1'b0, 1'b0}; py = '{1'b0, 1'b0};
    clr(0);
    clr(1);
    set_cfg(0, 0, 0);
    set_cfg(1, 1, 0);

    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_a", {busy_a, done_a, sclk_a, load_a, srst_a, d1_a, d2_a}, 0);
    chk("rst_out_b", {busy_b, done_b, sclk_b, load_b, srst_b, d1_b, d2_b}, 0);
    resetn = 1'b1;
    clr(0);
    clr(1);
    #1 chk("srst_before_edge", srst_a, 1'b0);
    @(negedge clk);
    chk("srst_after_edge", srst_a, 1'b1);
    chk("busy_first_cycle", busy_a, 1'b0);
    @(negedge clk);
`ifdef GPIO_LOADER_AUTOSTART_EN
    chk("auto_busy_a", busy_a, 1'b1);
    chk("auto_busy_b", busy_b, 1'b1);
    wait_done(0, 1000);
    wait_done(1, 3000);
    repeat (3) @(negedge clk);
    check_run(0, 2 * (NB + 1), 2);
    check_run(1, 6 * (NB + 1), 6);
`else
    repeat (3) @(negedge clk);
    chk("idle_out_a", {busy_a, done_a, sclk_a, load_a, d1_a, d2_a}, 0);
    chk("idle_out_b", {busy_b, done_b, sclk_b, load_b, d1_b, d2_b}, 0);
    chk("idle_srst_a", srst_a, 1'b1);
    chk("idle_srst_b", srst_b, 1'b1);
`endif

    // Basic sequence, pad n = 13'h1000|n.
    set_cfg(0, 0, 0);
    pulse(0);
    wait_done(0, 1000);
    repeat (3) @(negedge clk);
    check_run(0, 496, 2);
    chk("pad18", pad_rx(0, 18), 13'h1012);
    chk("pad19", pad_rx(0, 19), 13'h1013);
    chk("pad0", pad_rx(0, 0), 13'h1000);
    chk("pad37", pad_rx(0, 37), 13'h1025);

    // Restart attempt and cfg change mid-shift have no effect.
    set_cfg(0, 1, 0);
    pulse(0);
    wait_rise(0, 50);
    #1;
    start1 = 1'b1;
    set_cfg(0, 2, 1);
    @(negedge clk); #1;
    start1 = 1'b0;
    wait_done(0, 1000);
    #1;
    start1 = 1'b1;
    @(negedge clk); #1;
    chk("start_on_done_ignored", busy_a, 1'b0);
    check_run(0, 496, 2);
    clr(0);
    @(negedge clk); #1;
    start1 = 1'b0;
    chk("start_after_done", busy_a, 1'b1);
    set_cfg(0, 2, 0);
    wait_done(0, 1000);
    repeat (3) @(negedge clk);
    check_run(0, 496, 2);

    // Asynchronous reset mid-sequence, then a fresh full run.
    set_cfg(0, 3, 0);
    pulse(0);
    wait_rise(0, 100);
    #2;
    resetn = 1'b0;
    #1;
    chk("midrst_out_a", {busy_a, done_a, sclk_a, load_a, srst_a, d1_a, d2_a}, 0);
    @(negedge clk); #1;
    resetn = 1'b1;
    set_cfg(0, 4, 0);
    clr(0);
    @(negedge clk); #1;
    start1 = 1'b1;
    @(negedge clk); #1;
    start1 = 1'b0;
    chk("post_rst_busy", busy_a, 1'b1);
    wait_done(0, 1000);
    repeat (3) @(negedge clk);
    check_run(0, 496, 2);

    // CLK_DIV=3 instance: phase lengths and stretched timing.
    for (int i = 0; i < 3000 && busy_b; i++) @(negedge clk);
    chk("b_idle", busy_b, 1'b0);
    set_cfg(1, 5, 0);
    pulse(1);
    wait_done(1, 4000);
    repeat (3) @(negedge clk);
    check_run(1, 1488, 6);
    chk("hi_min", m_hmin[1], 3);
    chk("hi_max", m_hmax[1], 3);
    chk("lo_min", m_lmin[1], 3);
    chk("lo_max", m_lmax[1], 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
